io_out_regs: RTL and testbench
==============================

IO_OUT_REGS -- requirements
Module: io_out_regs

Interface
REQ-001 Parameter LCD_PULSE, default 4: LCD enable-pulse width in cycles; legal range 1-255.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 i_addr  in  32  LSU byte address, word-aligned; bits [1:0] ignored.
REQ-005 i_wdata  in  32  LSU store data.
REQ-006 i_be  in  4  store byte enables; bit n selects i_wdata[8n+7:8n].
REQ-007 i_we  in  1  store strobe, one cycle per store.
REQ-008 o_rdata  out  32  combinational readback of the addressed register.
REQ-009 o_io_ledr  out  32  red LED register.
REQ-010 o_io_ledg  out  32  green LED register.
REQ-011 o_io_hex0..o_io_hex7  out  7 each  seven-segment outputs, active-low.
REQ-012 o_io_lcd  out  32  LCD pins: [7:0] data, [8] RS, [9] RW, [10] EN, [31] ON.
REQ-013 o_lcd_busy  out  1  high while the LCD sequencer is not IDLE.

Function
REQ-014 Address map: 0x7000 LEDR, 0x7010 LEDG, 0x7020 HEX_LO (bytes 0-3 -> hex0-3), 0x7024 HEX_HI (bytes 0-3 -> hex4-7), 0x7030 LCD_CMD, 0x7034 LCD_STAT.
REQ-015 A store with i_we=1 to LEDR, LEDG, HEX_LO or HEX_HI updates only the enabled bytes on the same rising edge, so the new value is visible on outputs one cycle after the store.
REQ-016 A store to an unmapped address has no effect.
REQ-017 o_rdata returns the addressed register's stored value; for LCD_STAT it returns {30'b0, overrun, busy}; for unmapped addresses it returns 0.
REQ-018 The LCD sequencer has four states: IDLE, SETUP, PULSE and HOLD.
REQ-019 IDLE -> SETUP on a store to LCD_CMD; this captures wdata[9:0] into the pin latch with EN=0.
REQ-020 The sequencer stays in SETUP for 2 cycles, then enters PULSE.
REQ-021 The sequencer stays in PULSE for exactly LCD_PULSE cycles with EN=1, then enters HOLD with EN=0.
REQ-022 The sequencer stays in HOLD for 2 cycles, then returns to IDLE.
REQ-023 An LCD_CMD store with i_be[1:0] not equal to 2'b11 is ignored.
REQ-024 Bit 31 (ON) of an LCD_CMD store with i_be[3]=1 updates immediately in any state and does not start a sequence.
REQ-025 An LCD_CMD store while o_lcd_busy=1 is dropped, sets sticky overrun, and leaves the sequence undisturbed.
REQ-026 A store to LCD_STAT with wdata[1]=1 clears overrun; if an overrun event occurs in the same cycle, the set wins.
REQ-027 A store that completes the HOLD->IDLE transition cycle is accepted, so back-to-back commands are possible with zero gap.
REQ-028 The pulse counter is 8 bits wide, loaded with LCD_PULSE-1, and never wraps.

Reset
REQ-029 While rstn=0 at a clock edge, the block drives: LEDR=0, LEDG=0, all HEX registers to 0x7F (segments off), o_io_lcd=0, overrun=0, sequencer in IDLE, o_lcd_busy=0.
REQ-030 Reset asserted mid-sequence aborts the sequence, drives EN low at that edge, and discards the pending command.

Configuration
REQ-031 With IO_HEX_DECODE_EN defined, each HEX byte's low nibble is decoded to active-low segments (0-9, A-F; e.g. 0x0 -> 0x40, 0x8 -> 0x00).
REQ-032 With IO_HEX_DECODE_EN defined, HEX readback returns the stored nibble bytes.
REQ-033 Without IO_HEX_DECODE_EN, byte bits [6:0] drive the segments directly and bit 7 is stored but unused.

Verification
REQ-034 Reset, then a store of 0x00000001 to 0x7000 with be=0xF -> o_io_ledr=0x00000001 one cycle later; o_io_ledg stays 0.
REQ-035 A store of 0xAABBCCDD to 0x7010 with be=0x4 over LEDG=0 -> o_io_ledg=0x00BB0000.
REQ-036 A store of 0x00000155 to 0x7030 (LCD_PULSE=4) -> busy for 2+4+2=8 cycles; EN high for exactly 4 cycles; data=0x55 and RS=1 throughout.
REQ-037 A second LCD_CMD store 3 cycles into the sequence -> command ignored; LCD_STAT reads 0x3; a store of 0x2 to 0x7034 after IDLE -> LCD_STAT reads 0x0.
REQ-038 rstn pulsed low during PULSE -> next cycle EN=0, busy=0, o_io_lcd=0.
REQ-039 IO_HEX_DECODE_EN defined, store of 0x00000008 to 0x7020 -> hex0=0x00; hex1-3=0x40.

Source files
------------

// File: rtl/io_out_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : io_out_regs_if
// Brief    : LSU store/readback bus between the core and the output registers.
// Revision : 1.0  initial release
// ============================================================================
interface io_out_regs_if;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_be;
    logic        i_we;
    logic [31:0] o_rdata;

    modport master (
        output i_addr,
        output i_wdata,
        output i_be,
        output i_we,
        input  o_rdata
    );

    modport slave (
        input  i_addr,
        input  i_wdata,
        input  i_be,
        input  i_we,
        output o_rdata
    );
endinterface
`default_nettype wire

// File: rtl/io_out_regs.sv
`default_nettype none
// ============================================================================
// Module   : io_out_regs
// Brief    : Memory-mapped LED, seven-segment and LCD output registers.
//            The LCD port is driven by a SETUP/PULSE/HOLD sequencer.
//            Optional macro IO_HEX_DECODE_EN adds a hex-nibble segment decoder.
// Revision : 1.0  initial release
// ============================================================================
module io_out_regs #(
    parameter int unsigned LCD_PULSE = 4
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    io_out_regs_if.slave     bus,
    output logic [31:0]      o_io_ledr,
    output logic [31:0]      o_io_ledg,
    output logic [6:0]       o_io_hex0,
    output logic [6:0]       o_io_hex1,
    output logic [6:0]       o_io_hex2,
    output logic [6:0]       o_io_hex3,
    output logic [6:0]       o_io_hex4,
    output logic [6:0]       o_io_hex5,
    output logic [6:0]       o_io_hex6,
    output logic [6:0]       o_io_hex7,
    output logic [31:0]      o_io_lcd,
    output logic             o_lcd_busy
);

    localparam logic [31:0] c_addr_ledr     = 32'h0000_7000;
    localparam logic [31:0] c_addr_ledg     = 32'h0000_7010;
    localparam logic [31:0] c_addr_hex_lo   = 32'h0000_7020;
    localparam logic [31:0] c_addr_hex_hi   = 32'h0000_7024;
    localparam logic [31:0] c_addr_lcd_cmd  = 32'h0000_7030;
    localparam logic [31:0] c_addr_lcd_stat = 32'h0000_7034;
    localparam logic [31:0] c_hex_rst       = 32'h7F7F_7F7F;
    localparam logic [7:0]  c_pulse_load    = 8'(LCD_PULSE - 1);
    localparam logic [7:0]  c_edge_load     = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } lcd_state_t;

    lcd_state_t  r_state;
    lcd_state_t  w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;

    logic [31:0] r_ledr;
    logic [31:0] r_ledg;
    logic [31:0] r_hex_lo;
    logic [31:0] r_hex_hi;
    logic [9:0]  r_lcd_pins;
    logic        r_lcd_on;
    logic        r_overrun;

    logic [31:0] w_word;
    logic        w_unused_addr;
    logic        w_sel_ledr;
    logic        w_sel_ledg;
    logic        w_sel_hex_lo;
    logic        w_sel_hex_hi;
    logic        w_sel_cmd;
    logic        w_sel_stat;
    logic        w_cmd_wr;
    logic        w_can_accept;
    logic        w_cmd_accept;
    logic        w_overrun_set;
    logic        w_overrun_clr;
    logic        w_lcd_en;
    logic [63:0] w_hex_bytes;
    logic [6:0]  w_seg [8];

    function automatic logic [31:0] f_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] w_res;
        w_res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                w_res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return w_res;
    endfunction

    // Decode is on the full word address; only the byte offset is dropped.
    assign w_word        = {bus.i_addr[31:2], 2'b00};
    assign w_unused_addr = ^bus.i_addr[1:0];

    assign w_sel_ledr   = (w_word == c_addr_ledr);
    assign w_sel_ledg   = (w_word == c_addr_ledg);
    assign w_sel_hex_lo = (w_word == c_addr_hex_lo);
    assign w_sel_hex_hi = (w_word == c_addr_hex_hi);
    assign w_sel_cmd    = (w_word == c_addr_lcd_cmd);
    assign w_sel_stat   = (w_word == c_addr_lcd_stat);

    // The final HOLD cycle may accept a new command so commands can chain.
    assign w_cmd_wr      = bus.i_we && w_sel_cmd && (bus.i_be[1:0] == 2'b11);
    assign w_can_accept  = (r_state == ST_IDLE) ||
                           ((r_state == ST_HOLD) && (r_cnt == 8'd0));
    assign w_cmd_accept  = w_cmd_wr && w_can_accept;
    assign w_overrun_set = w_cmd_wr && !w_can_accept;
    assign w_overrun_clr = bus.i_we && w_sel_stat && bus.i_wdata[1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter only decrements while non-zero, so it never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_accept) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_edge_load;
                end
            end
            ST_SETUP: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = c_pulse_load;
                end else begin
                    w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            ST_PULSE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_edge_load;
                end else begin
                    w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            ST_HOLD: begin
                if (w_cmd_accept) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_edge_load;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ledr     <= 32'd0;
            r_ledg     <= 32'd0;
            r_hex_lo   <= c_hex_rst;
            r_hex_hi   <= c_hex_rst;
            r_lcd_pins <= 10'd0;
            r_lcd_on   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (bus.i_we && w_sel_ledr) begin
                r_ledr <= f_merge(r_ledr, bus.i_wdata, bus.i_be);
            end
            if (bus.i_we && w_sel_ledg) begin
                r_ledg <= f_merge(r_ledg, bus.i_wdata, bus.i_be);
            end
            if (bus.i_we && w_sel_hex_lo) begin
                r_hex_lo <= f_merge(r_hex_lo, bus.i_wdata, bus.i_be);
            end
            if (bus.i_we && w_sel_hex_hi) begin
                r_hex_hi <= f_merge(r_hex_hi, bus.i_wdata, bus.i_be);
            end
            if (w_cmd_accept) begin
                r_lcd_pins <= bus.i_wdata[9:0];
            end
            // ON is a direct control bit, independent of the sequencer.
            if (bus.i_we && w_sel_cmd && bus.i_be[3]) begin
                r_lcd_on <= bus.i_wdata[31];
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign w_lcd_en   = (r_state == ST_PULSE);
    assign o_lcd_busy = (r_state != ST_IDLE);
    assign o_io_lcd   = {r_lcd_on, 20'd0, w_lcd_en, r_lcd_pins};
    assign o_io_ledr  = r_ledr;
    assign o_io_ledg  = r_ledg;

    assign w_hex_bytes = {r_hex_hi, r_hex_lo};

`ifdef IO_HEX_DECODE_EN
    function automatic logic [6:0] f_seg(input logic [3:0] nib);
        logic [6:0] w_s;
        case (nib)
            4'h0: w_s = 7'h40;
            4'h1: w_s = 7'h79;
            4'h2: w_s = 7'h24;
            4'h3: w_s = 7'h30;
            4'h4: w_s = 7'h19;
            4'h5: w_s = 7'h12;
            4'h6: w_s = 7'h02;
            4'h7: w_s = 7'h78;
            4'h8: w_s = 7'h00;
            4'h9: w_s = 7'h10;
            4'hA: w_s = 7'h08;
            4'hB: w_s = 7'h03;
            4'hC: w_s = 7'h46;
            4'hD: w_s = 7'h21;
            4'hE: w_s = 7'h06;
            default: w_s = 7'h0E;
        endcase
        return w_s;
    endfunction

    for (genvar g = 0; g < 8; g++) begin : g_hex_dec
        assign w_seg[g] = f_seg(w_hex_bytes[8*g +: 4]);
    end
`else
    for (genvar g = 0; g < 8; g++) begin : g_hex_raw
        assign w_seg[g] = w_hex_bytes[8*g +: 7];
    end
`endif

    assign o_io_hex0 = w_seg[0];
    assign o_io_hex1 = w_seg[1];
    assign o_io_hex2 = w_seg[2];
    assign o_io_hex3 = w_seg[3];
    assign o_io_hex4 = w_seg[4];
    assign o_io_hex5 = w_seg[5];
    assign o_io_hex6 = w_seg[6];
    assign o_io_hex7 = w_seg[7];

    always_comb begin
        bus.o_rdata = 32'd0;
        if (w_sel_ledr) begin
            bus.o_rdata = r_ledr;
        end else if (w_sel_ledg) begin
            bus.o_rdata = r_ledg;
        end else if (w_sel_hex_lo) begin
            bus.o_rdata = r_hex_lo;
        end else if (w_sel_hex_hi) begin
            bus.o_rdata = r_hex_hi;
        end else if (w_sel_cmd) begin
            bus.o_rdata = o_io_lcd;
        end else if (w_sel_stat) begin
            bus.o_rdata = {30'd0, r_overrun, o_lcd_busy};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_out_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_out_regs
// Brief    : Randomized and directed bench for io_out_regs against a timeline
//            model of the registers and LCD sequencer (honours IO_HEX_DECODE_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_io_out_regs;
    localparam int P   = 4;
    localparam int BIG = 1000;
    localparam logic [31:0] ADDRS [8] = '{32'h7000, 32'h7010, 32'h7020, 32'h7024,
                                          32'h7030, 32'h7034, 32'h7004, 32'h17030};

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [31:0] lcd;
    logic [6:0]  hex [8];
    logic        busy;

    io_out_regs_if bus();

    io_out_regs #(.LCD_PULSE(P)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .o_io_ledr(ledr), .o_io_ledg(ledg),
        .o_io_hex0(hex[0]), .o_io_hex1(hex[1]), .o_io_hex2(hex[2]), .o_io_hex3(hex[3]),
        .o_io_hex4(hex[4]), .o_io_hex5(hex[5]), .o_io_hex6(hex[6]), .o_io_hex7(hex[7]),
        .o_io_lcd(lcd), .o_lcd_busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: register contents plus the age (edges since the last accepted command).
    logic [31:0] m_ledr  = 32'd0;
    logic [31:0] m_ledg  = 32'd0;
    logic [31:0] m_hexlo = 32'h7F7F7F7F;
    logic [31:0] m_hexhi = 32'h7F7F7F7F;
    logic [9:0]  m_pins  = 10'd0;
    logic        m_on    = 1'b0;
    logic        m_ovr   = 1'b0;
    int          m_age   = BIG;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic logic exp_busy();
        return m_age < 4 + P;
    endfunction

    function automatic logic exp_en();
        return (m_age >= 2) && (m_age < 2 + P);
    endfunction

    function automatic logic [6:0] exp_hex(input int i);
        logic [63:0] all;
        logic [7:0]  b;
        all = {m_hexhi, m_hexlo};
        b   = all[8*i +: 8];
`ifdef IO_HEX_DECODE_EN
        return seg_tab[b[3:0]];
`else
        return b[6:0];
`endif
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        case ({a[31:2], 2'b00})
            32'h7000: return m_ledr;
            32'h7010: return m_ledg;
            32'h7020: return m_hexlo;
            32'h7024: return m_hexhi;
            32'h7034: return {30'd0, m_ovr, exp_busy()};
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_update(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic rst_n);
        logic set_o, clr_o;
        int   age_next;
        if (!rst_n) begin
            m_ledr = 0; m_ledg = 0; m_hexlo = 32'h7F7F7F7F; m_hexhi = 32'h7F7F7F7F;
            m_pins = 0; m_on = 0; m_ovr = 0; m_age = BIG;
            return;
        end
        set_o = 0; clr_o = 0;
        age_next = (m_age >= BIG) ? BIG : m_age + 1;
        if (we) begin
            case ({a[31:2], 2'b00})
                32'h7000: m_ledr  = merge(m_ledr, d, be);
                32'h7010: m_ledg  = merge(m_ledg, d, be);
                32'h7020: m_hexlo = merge(m_hexlo, d, be);
                32'h7024: m_hexhi = merge(m_hexhi, d, be);
                32'h7030: begin
                    if (be[3]) m_on = d[31];
                    if (be[1:0] == 2'b11) begin
                        if (m_age >= 3 + P) begin
                            m_pins   = d[9:0];
                            age_next = 0;
                        end else begin
                            set_o = 1;
                        end
                    end
                end
                32'h7034: clr_o = d[1];
                default: ;
            endcase
        end
        if (set_o)      m_ovr = 1;
        else if (clr_o) m_ovr = 0;
        m_age = age_next;
    endtask

    task automatic check_outputs();
        check("ledr", ledr, m_ledr);
        check("ledg", ledg, m_ledg);
        for (int i = 0; i < 8; i++) check($sformatf("hex%0d", i), {25'd0, hex[i]}, {25'd0, exp_hex(i)});
        check("lcd", lcd, {m_on, 20'd0, exp_en(), m_pins});
        check("busy", {31'd0, busy}, {31'd0, exp_busy()});
    endtask

    // One bus cycle: drive at negedge, check readback, clock, check registered outputs.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic rst_n);
        bus.i_we = we; bus.i_addr = a; bus.i_wdata = d; bus.i_be = be; rstn = rst_n;
        #1;
        if (rst_n && ({a[31:2], 2'b00} != 32'h7030)) check("rdata", bus.o_rdata, exp_rdata(a));
        @(posedge clk);
        model_update(we, a, d, be, rst_n);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h7034, 32'd0, 4'h0, 1'b1);
    endtask

    initial begin
        int nb, ne, bad;
        logic [31:0] a, d;
        logic [3:0]  be;
        logic        we, rn;
        int          idx;

        bus.i_we = 0; bus.i_addr = 0; bus.i_wdata = 0; bus.i_be = 0;
        @(negedge clk);
        cycle(0, 32'h7034, 0, 0, 0);
        cycle(0, 32'h7034, 0, 0, 0);
        check("rst_ledr", ledr, 32'd0);
        check("rst_hex0", {25'd0, hex[0]}, 32'h7F);
        check("rst_lcd", lcd, 32'd0);
        idle(1);
        check("rst_stat", bus.o_rdata, 32'd0);

        cycle(1, 32'h7000, 32'h1, 4'hF, 1);
        check("ledr_word", ledr, 32'h1);
        check("ledg_kept", ledg, 32'h0);
        cycle(1, 32'h7010, 32'hAABBCCDD, 4'h4, 1);
        check("ledg_byte2", ledg, 32'h00BB0000);
        cycle(1, 32'h7004, 32'hFFFFFFFF, 4'hF, 1);
        check("unmapped", ledr, 32'h1);

        // Single command: busy/EN window lengths and stable pins.
        cycle(1, 32'h7030, 32'h155, 4'hF, 1);
        nb = 0; ne = 0; bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy) nb++;
            if (lcd[10]) ne++;
            if (busy && (lcd[7:0] != 8'h55 || !lcd[8])) bad++;
            idle(1);
        end
        check("busy_len", nb, 8);
        check("en_len", ne, P);
        check("lcd_pins", bad, 0);

        // Overrun while busy, then clear.
        cycle(1, 32'h7030, 32'h155, 4'hF, 1);
        idle(2);
        cycle(1, 32'h7030, 32'h1AA, 4'hF, 1);
        idle(1);
        check("stat_ovr", bus.o_rdata, 32'h3);
        check("lcd_keep", {24'd0, lcd[7:0]}, 32'h55);
        idle(8);
        cycle(1, 32'h7034, 32'h2, 4'hF, 1);
        check("stat_clr", bus.o_rdata, 32'h0);

        // Zero-gap chaining on the last HOLD cycle.
        cycle(1, 32'h7030, 32'h133, 4'h3, 1);
        nb = 0;
        for (int k = 0; k < 7; k++) begin
            idle(1);
            if (busy) nb++;
        end
        cycle(1, 32'h7030, 32'h0C4, 4'h3, 1);
        check("chain_busy", nb, 7);
        check("chain_pins", {22'd0, lcd[9:0]}, 32'h0C4);
        idle(1);
        check("chain_stat", bus.o_rdata, 32'h1);
        idle(10);

        // Reset during PULSE.
        cycle(1, 32'h7030, 32'h155, 4'hF, 1);
        idle(2);
        check("en_pre", {31'd0, lcd[10]}, 32'h1);
        cycle(0, 32'h7034, 0, 0, 0);
        check("rst_mid_lcd", lcd, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        idle(1);

        cycle(1, 32'h7030, 32'h80000000, 4'h8, 1);
        check("lcd_on", lcd, 32'h80000000);
        check("on_nobusy", {31'd0, busy}, 32'd0);

`ifdef IO_HEX_DECODE_EN
        cycle(1, 32'h7020, 32'h8, 4'hF, 1);
        check("hex0_dec", {25'd0, hex[0]}, 32'h00);
        check("hex1_dec", {25'd0, hex[1]}, 32'h40);
`else
        cycle(1, 32'h7020, 32'h12345678, 4'hF, 1);
        check("hex0_raw", {25'd0, hex[0]}, 32'h78);
        check("hex3_raw", {25'd0, hex[3]}, 32'h12);
`endif

        for (int n = 0; n < 1500; n++) begin
            idx = $urandom_range(0, 9);
            if (idx > 7) idx = 4;
            a  = ADDRS[idx] | 32'($urandom_range(0, 3));
            d  = $urandom;
            be = 4'($urandom);
            we = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 199) != 0);
            cycle(we, a, d, be, rn);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
